// File: rtl/ppa_bist.sv
// ppa_bist: self-test engine for the 16-bit parallel-prefix adder.
//   Drives A/B/Cin, then checks S/Cout against an internal 17-bit golden sum.
//   Runs six directed vectors, then NUM_RAND LFSR vectors.
//   Ports: clk/rst (async active-high), start pulse; dut_a/dut_b/dut_cin out to
//   the adder; dut_s/dut_cout back from it; busy/done/pass/err_count status;
//   fail_* hold the first failing vector and the outputs observed for it.
module ppa_bist #(
  parameter int          WIDTH    = 16,
  parameter int          NUM_RAND = 256,
  parameter int          SETTLE   = 1,
  parameter logic [15:0] SEED_A   = 16'hACE1,
  parameter logic [15:0] SEED_B   = 16'h1D2C,
  parameter int          ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_s,
  output logic             fail_cout
);

  localparam logic [15:0] LAST_IDX   = 16'(6 + NUM_RAND - 1);
  // WAIT lasts SETTLE-1 cycles; the counter runs 0..SETTLE-2.
  localparam logic [15:0] WAIT_LAST  = 16'((SETTLE > 1) ? (SETTLE - 2) : 0);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_A_EFF = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SEED_B_EFF = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [15:0]      wait_q, wait_d;
  logic [15:0]      lfsr_a_q, lfsr_a_d;
  logic [15:0]      lfsr_b_q, lfsr_b_d;
  logic [16:0]      gold_q, gold_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d;
  logic [WIDTH-1:0] dut_b_q, dut_b_d;
  logic             dut_cin_q, dut_cin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             fail_cin_q, fail_cin_d;
  logic [WIDTH-1:0] fail_s_q, fail_s_d;
  logic             fail_cout_q, fail_cout_d;

  logic [15:0] vec_a;
  logic [15:0] vec_b;
  logic        vec_cin;
  logic        accept;

  // Fibonacci LFSR, taps 16,14,13,11, shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Vector selection for the current index: directed table, else LFSRs.
  always_comb begin
    vec_a   = lfsr_a_q;
    vec_b   = lfsr_b_q;
    vec_cin = lfsr_a_q[0] ^ lfsr_b_q[15];
    if (idx_q < 16'd6) begin
      case (idx_q[2:0])
        3'd0: begin vec_a = 16'h0000; vec_b = 16'h0000; vec_cin = 1'b0; end
        3'd1: begin vec_a = 16'h0001; vec_b = 16'h0002; vec_cin = 1'b0; end
        3'd2: begin vec_a = 16'hFFFF; vec_b = 16'h0001; vec_cin = 1'b0; end
        3'd3: begin vec_a = 16'h1234; vec_b = 16'h5678; vec_cin = 1'b0; end
        3'd4: begin vec_a = 16'hAAAA; vec_b = 16'h5555; vec_cin = 1'b1; end
        3'd5: begin vec_a = 16'hFFFF; vec_b = 16'hFFFF; vec_cin = 1'b1; end
        default: ;
      endcase
    end
  end

  // DONE is entered while busy is still high; start is only taken once the
  // DONE state has published its status and dropped busy.
  assign accept = start && !busy_q && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    gold_d      = gold_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    dut_cin_d   = dut_cin_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_idx_d  = fail_idx_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_cin_d  = fail_cin_q;
    fail_s_d    = fail_s_q;
    fail_cout_d = fail_cout_q;

    if (accept) begin
      state_d     = S_DRIVE;
      idx_d       = 16'd0;
      wait_d      = 16'd0;
      lfsr_a_d    = SEED_A_EFF;
      lfsr_b_d    = SEED_B_EFF;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      err_d       = '0;
      fail_idx_d  = 16'd0;
      fail_a_d    = '0;
      fail_b_d    = '0;
      fail_cin_d  = 1'b0;
      fail_s_d    = '0;
      fail_cout_d = 1'b0;
    end else begin
      case (state_q)
        S_DRIVE: begin
          dut_a_d   = vec_a;
          dut_b_d   = vec_b;
          dut_cin_d = vec_cin;
          gold_d    = {1'b0, vec_a} + {1'b0, vec_b} + {16'd0, vec_cin};
          // LFSRs step after the random vector has been taken from them.
          if (idx_q >= 16'd6) begin
            lfsr_a_d = lfsr_next(lfsr_a_q);
            lfsr_b_d = lfsr_next(lfsr_b_q);
          end
          wait_d  = 16'd0;
          state_d = (SETTLE == 1) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_d = S_CHECK;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
        S_CHECK: begin
          if ({dut_cout, dut_s} != gold_q) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
            // err_count never returns to zero mid-run, so zero marks "no
            // failure captured yet".
            if (err_q == '0) begin
              fail_idx_d  = idx_q;
              fail_a_d    = dut_a_q;
              fail_b_d    = dut_b_q;
              fail_cin_d  = dut_cin_q;
              fail_s_d    = dut_s;
              fail_cout_d = dut_cout;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_DRIVE;
          end
        end
        S_DONE: begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 16'd0;
      wait_q      <= 16'd0;
      lfsr_a_q    <= SEED_A_EFF;
      lfsr_b_q    <= SEED_B_EFF;
      gold_q      <= 17'd0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
      dut_cin_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_idx_q  <= 16'd0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_cin_q  <= 1'b0;
      fail_s_q    <= '0;
      fail_cout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      gold_q      <= gold_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_cin_q   <= dut_cin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_idx_q  <= fail_idx_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_cin_q  <= fail_cin_d;
      fail_s_q    <= fail_s_d;
      fail_cout_q <= fail_cout_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign dut_cin   = dut_cin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_idx  = fail_idx_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_cin  = fail_cin_q;
  assign fail_s    = fail_s_q;
  assign fail_cout = fail_cout_q;

endmodule

// File: tb/tb_ppa_bist.sv
// Testbench for ppa_bist: three engines beside adder models (one with
// selectable faults, one correct with SETTLE=3, one always wrong with ERR_W=2).
// Expected vectors and run results are queued at start; monitors compare.
module tb_ppa_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ---------------- u0: NUM_RAND=0, SETTLE=1, fault-selectable adder
  logic start0, cin0, cout0, busy0, done0, pass0, fcin0, fcout0;
  logic [15:0] a0, b0, s0, fidx0, fa0, fb0, fs0;
  logic [7:0]  err0;
  logic [16:0] sum0;
  int mode0;
  assign sum0 = {1'b0, a0} + {1'b0, b0} + {16'd0, cin0};
  always_comb begin
    s0    = sum0[15:0];
    cout0 = sum0[16];
    if (mode0 == 1) s0[0] = 1'b0;
    if (mode0 == 2) cout0 = 1'b0;
  end

  ppa_bist #(.NUM_RAND(0), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_s(s0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_idx(fidx0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0),
    .fail_s(fs0), .fail_cout(fcout0));

  // ---------------- u1: NUM_RAND=256, SETTLE=3, correct adder
  logic start1, cin1, cout1, busy1, done1, pass1, fcin1, fcout1;
  logic [15:0] a1, b1, s1, fidx1, fa1, fb1, fs1;
  logic [7:0]  err1;
  assign {cout1, s1} = {1'b0, a1} + {1'b0, b1} + {16'd0, cin1};

  ppa_bist #(.NUM_RAND(256), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_s(s1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_idx(fidx1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fcin1),
    .fail_s(fs1), .fail_cout(fcout1));

  // ---------------- u2: NUM_RAND=10, ERR_W=2, sum always inverted
  logic start2, cin2, cout2, busy2, done2, pass2, fcin2, fcout2;
  logic [15:0] a2, b2, s2, fidx2, fa2, fb2, fs2;
  logic [1:0]  err2;
  logic [16:0] sum2;
  assign sum2  = {1'b0, a2} + {1'b0, b2} + {16'd0, cin2};
  assign s2    = ~sum2[15:0];
  assign cout2 = sum2[16];

  ppa_bist #(.NUM_RAND(10), .SETTLE(1), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_cin(cin2), .dut_s(s2), .dut_cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_idx(fidx2), .fail_a(fa2), .fail_b(fb2), .fail_cin(fcin2),
    .fail_s(fs2), .fail_cout(fcout2));

  // ---------------- scoreboard
  typedef struct {
    int inst; int cyc; logic [15:0] a; logic [15:0] b; logic cin;
  } vec_t;
  typedef struct {
    int cyc; logic [7:0] err; logic pass; logic [15:0] idx;
    logic [15:0] a; logic [15:0] b; logic cin; logic [15:0] s; logic cout;
  } res_t;

  vec_t vq[$];
  res_t rq0[$], rq1[$], rq2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input int inst, input int c, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
    vec_t e;
    e.inst = inst; e.cyc = c; e.a = a; e.b = b; e.cin = cin;
    vq.push_back(e);
  endtask

  function automatic res_t mk_res(input int c, input logic [7:0] err, input logic pass,
                                  input logic [15:0] idx, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin,
                                  input logic [15:0] s, input logic cout);
    res_t r;
    r.cyc = c; r.err = err; r.pass = pass; r.idx = idx; r.a = a; r.b = b;
    r.cin = cin; r.s = s; r.cout = cout;
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t e, input logic busy,
                         input logic [7:0] err, input logic pass, input logic [15:0] idx,
                         input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] s, input logic cout);
    chk({tag, " done_cycle"}, cyc, e.cyc);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " err_count"}, err, e.err);
    chk({tag, " pass"}, pass, e.pass);
    chk({tag, " fail_idx"}, idx, e.idx);
    chk({tag, " fail_a"}, a, e.a);
    chk({tag, " fail_b"}, b, e.b);
    chk({tag, " fail_cin"}, cin, e.cin);
    chk({tag, " fail_s"}, s, e.s);
    chk({tag, " fail_cout"}, cout, e.cout);
  endtask

  task automatic unexpected(input string tag);
    checks++;
    failures++;
    $display("FAIL %s unexpected_done actual=1 required=0", tag);
  endtask

  // Vector monitor: compares driven operands at the expected cycle.
  always @(negedge clk) begin
    vec_t e;
    logic [15:0] ga, gb;
    logic gc;
    while (vq.size() > 0 && vq[0].cyc <= cyc) begin
      e = vq.pop_front();
      case (e.inst)
        0:       begin ga = a0; gb = b0; gc = cin0; end
        1:       begin ga = a1; gb = b1; gc = cin1; end
        default: begin ga = a2; gb = b2; gc = cin2; end
      endcase
      chk($sformatf("vec_cycle u%0d", e.inst), cyc, e.cyc);
      chk($sformatf("vec_a u%0d c%0d", e.inst, e.cyc), ga, e.a);
      chk($sformatf("vec_b u%0d c%0d", e.inst, e.cyc), gb, e.b);
      chk($sformatf("vec_cin u%0d c%0d", e.inst, e.cyc), gc, e.cin);
    end
  end

  // Result monitors: fire on each rising edge of done.
  logic done0_p = 1'b0, done1_p = 1'b0, done2_p = 1'b0;
  always @(negedge clk) begin
    done0_p <= done0;
    if (done0 && !done0_p) begin
      if (rq0.size() == 0) unexpected("u0");
      else cmp_res("u0", rq0.pop_front(), busy0, err0, pass0, fidx0, fa0, fb0, fcin0, fs0, fcout0);
    end
  end
  always @(negedge clk) begin
    done1_p <= done1;
    if (done1 && !done1_p) begin
      if (rq1.size() == 0) unexpected("u1");
      else cmp_res("u1", rq1.pop_front(), busy1, err1, pass1, fidx1, fa1, fb1, fcin1, fs1, fcout1);
    end
  end
  always @(negedge clk) begin
    done2_p <= done2;
    if (done2 && !done2_p) begin
      if (rq2.size() == 0) unexpected("u2");
      else cmp_res("u2", rq2.pop_front(), busy2, {6'd0, err2}, pass2, fidx2, fa2, fb2, fcin2, fs2, fcout2);
    end
  end

  // ---------------- stimulus helpers
  function automatic logic dn(input int inst);
    return (inst == 0) ? done0 : (inst == 1) ? done1 : done2;
  endfunction

  // Pulses start for one cycle; t0 is the edge that samples it.
  task automatic go(input int inst, output int t0);
    @(negedge clk);
    case (inst)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    t0 = cyc + 1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int inst, input int limit);
    int n = 0;
    while (!dn(inst) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_done u%0d", inst), dn(inst), 1'b1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_directed0(input int t0);
    push_vec(0, t0 + 1,  16'h0000, 16'h0000, 1'b0);
    push_vec(0, t0 + 3,  16'h0001, 16'h0002, 1'b0);
    push_vec(0, t0 + 5,  16'hFFFF, 16'h0001, 1'b0);
    push_vec(0, t0 + 7,  16'h1234, 16'h5678, 1'b0);
    push_vec(0, t0 + 9,  16'hAAAA, 16'h5555, 1'b1);
    push_vec(0, t0 + 11, 16'hFFFF, 16'hFFFF, 1'b1);
  endtask

  // Vectors 0, 3, and the first two random ones, for the SETTLE=3 engine.
  task automatic push_u1(input int t0);
    push_vec(1, t0 + 1,  16'h0000, 16'h0000, 1'b0);
    push_vec(1, t0 + 13, 16'h1234, 16'h5678, 1'b0);
    push_vec(1, t0 + 25, 16'hACE1, 16'h1D2C, 1'b1);
    push_vec(1, t0 + 29, 16'h59C3, 16'h3A58, 1'b1);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0;
    repeat (2) @(negedge clk);

    chk("rst busy0", busy0, 1'b0);
    chk("rst done0", done0, 1'b0);
    chk("rst pass0", pass0, 1'b0);
    chk("rst err0", err0, 8'd0);
    chk("rst a0", a0, 16'h0000);
    chk("rst fidx0", fidx0, 16'h0000);
    chk("rst fs0", fs0, 16'h0000);
    chk("rst busy1", busy1, 1'b0);
    chk("rst err2", err2, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Correct adder, directed set only.
    mode0 = 0;
    go(0, t0);
    push_directed0(t0);
    rq0.push_back(mk_res(t0 + 13, 8'd0, 1'b1, 16'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0));
    wait_done(0, 40);

    // S[0] stuck at 0: vectors 1 and 5 fail.
    mode0 = 1;
    go(0, t0);
    rq0.push_back(mk_res(t0 + 13, 8'd2, 1'b0, 16'd1, 16'h0001, 16'h0002, 1'b0, 16'h0002, 1'b0));
    wait_done(0, 40);

    // Cout stuck at 0: vectors 2, 4, 5 fail.
    mode0 = 2;
    go(0, t0);
    rq0.push_back(mk_res(t0 + 13, 8'd3, 1'b0, 16'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0));
    wait_done(0, 40);

    // Long run with random vectors, twice back to back.
    for (int r = 0; r < 2; r++) begin
      go(1, t0);
      push_u1(t0);
      rq1.push_back(mk_res(t0 + 1049, 8'd0, 1'b1, 16'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0));
      wait_done(1, 1100);
    end

    // Reset while waiting on vector 3.
    go(1, t0);
    push_vec(1, t0 + 1,  16'h0000, 16'h0000, 1'b0);
    push_vec(1, t0 + 13, 16'h1234, 16'h5678, 1'b0);
    wait_cyc(t0 + 14);
    rst = 1'b1;
    #1;
    chk("midrst busy1", busy1, 1'b0);
    chk("midrst done1", done1, 1'b0);
    chk("midrst a1", a1, 16'h0000);
    chk("midrst b1", b1, 16'h0000);
    chk("midrst cin1", cin1, 1'b0);
    chk("midrst err1", err1, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    go(1, t0);
    push_u1(t0);
    rq1.push_back(mk_res(t0 + 1049, 8'd0, 1'b1, 16'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0));
    wait_done(1, 1100);

    // Always-wrong adder: error count saturates; starts while busy ignored.
    go(2, t0);
    rq2.push_back(mk_res(t0 + 33, 8'd3, 1'b0, 16'd0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0));
    wait_cyc(t0 + 10);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_cyc(t0 + 20);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(2, 60);

    repeat (3) @(negedge clk);
    chk("leftover vectors", vq.size(), 0);
    chk("leftover u0", rq0.size(), 0);
    chk("leftover u1", rq1.size(), 0);
    chk("leftover u2", rq2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
